instruction_fetch_unit: RTL

//   Upstream neighbour of the control unit. Owns the program counter and fetches

---
 rtl/instruction_fetch_unit_if.sv | 25 ++
 rtl/instruction_fetch_unit.sv | 106 ++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory read channel.
// Fetch unit drives req/addr; memory answers with ack/rdata.
interface instruction_fetch_unit_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
);
  logic               req;
  logic [ADDR_W-1:0]  addr;
  logic               ack;
  logic [INSTR_W-1:0] rdata;

  modport master (
    output req,
    output addr,
    input  ack,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output ack,
    output rdata
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Program counter owner and instruction fetcher.
// Fetches over req/ack, latches IR, advances PC on pc_read.
module instruction_fetch_unit #(
  parameter int              ADDR_W   = 8,
  parameter int              INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [2:0]      HALT_OP  = 3'b111
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pc_read,
  input  logic                branch_en,
  input  logic [ADDR_W-1:0]   branch_target,
  instruction_fetch_unit_if.master imem,
  output logic [ADDR_W-1:0]   pc,
  output logic [INSTR_W-1:0]  ir,
  output logic                id0,
  output logic                id1,
  output logic                id2,
  output logic                instr_valid,
  output logic                halted,
  output logic                protocol_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_WAIT,
    S_HALTED
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               instr_valid_q, instr_valid_d;
  logic               halted_q, halted_d;
  logic               protocol_err_q, protocol_err_d;

  // Next-state logic: fetch handshake, decode, PC update
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    ir_d           = ir_q;
    instr_valid_d  = 1'b0;
    unique case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (imem.ack) begin
          ir_d          = imem.rdata;
          instr_valid_d = 1'b1;
          state_d       = S_DECODE;
        end
      end
      S_DECODE: begin
        if (ir_q[INSTR_W-1 -: 3] == HALT_OP)
          state_d = S_HALTED;
        else
          state_d = S_WAIT;
      end
      S_WAIT: begin
        if (pc_read) begin
          pc_d    = branch_en ? branch_target
                              : pc_q + ADDR_W'(1);
          state_d = S_FETCH;
        end
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
    halted_d       = (state_d == S_HALTED);
    protocol_err_d = protocol_err_q
                   | (pc_read && state_q != S_WAIT);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      pc_q           <= RESET_PC;
      ir_q           <= '0;
      instr_valid_q  <= 1'b0;
      halted_q       <= 1'b0;
      protocol_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      ir_q           <= ir_d;
      instr_valid_q  <= instr_valid_d;
      halted_q       <= halted_d;
      protocol_err_q <= protocol_err_d;
    end
  end

  assign imem.req     = (state_q == S_FETCH);
  assign imem.addr    = pc_q;
  assign pc           = pc_q;
  assign ir           = ir_q;
  assign id2          = ir_q[INSTR_W-1];
  assign id1          = ir_q[INSTR_W-2];
  assign id0          = ir_q[INSTR_W-3];
  assign instr_valid  = instr_valid_q;
  assign halted       = halted_q;
  assign protocol_err = protocol_err_q;

endmodule
